alu_initiator: RTL and testbench
================================

# alu_initiator

Sequential initiator for the team's combinational 2-bit ALU (operands A/B, 2-bit select, 3-bit result, carry-out). It accepts operation commands over a valid/ready channel and buffers them in a small FIFO. It drives each command onto the ALU pins, samples the result after one settle cycle, and returns tagged responses over a second valid/ready channel. It also flags divide-by-zero, which the ALU itself does not detect.

## Interface
- DEPTH, 4: command FIFO entries (power of two, ≥2)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO can accept (!full)
- cmd_a, cmd_b  in  2 each  operands
- cmd_op  in  2  00 add, 01 sub, 10 mul, 11 div
- cmd_tag  in  2  opaque ID, returned unchanged
- alu_a, alu_b, alu_sel  out  2 each  driven to ALU
- alu_out  in  3  ALU result
- alu_carry  in  1  ALU carry-out
- rsp_valid  out  1  response held
- rsp_ready  in  1  consumer accepts
- rsp_result  out  3  result
- rsp_carry  out  1  carry (add only, else 0)
- rsp_dz  out  1  divide-by-zero
- rsp_tag  out  2  tag of command
- busy  out  1  FSM not IDLE or FIFO non-empty
- fifo_count  out  $clog2(DEPTH)+1  occupancy

## Operation
- Push when cmd_valid && cmd_ready. Pop when the FSM leaves IDLE or RESP toward DRIVE. Push and pop in the same cycle are legal, and the count is unchanged.
- cmd_ready = (fifo_count != DEPTH). It is combinational from the registered count. A pop in the same cycle does not free a slot for a push.
- FSM states:
  - IDLE: if FIFO is non-empty, pop into the operand register and go to DRIVE.
  - DRIVE: alu_a/alu_b/alu_sel come from the operand register. Go to CAPTURE.
  - CAPTURE: register alu_out/alu_carry into the response register, then go to RESP.
  - RESP: rsp_valid=1. On rsp_ready, if FIFO is non-empty, pop and go to DRIVE; otherwise go to IDLE.
- Divide-by-zero: op=11 and b=0 gives rsp_result=3'b111 and rsp_dz=1. alu_out is ignored, and the ALU is still driven.
- rsp_carry = alu_carry when op=00, else 0.
- Expected arithmetic, mod 8:
  - add: a+b
  - sub: (a−b) mod 8 (1−2 = 7)
  - mul: a*b mod 8 (3*3 = 1)
  - div: floor(a/b)
- alu_a/alu_b/alu_sel hold the last operand-register value in all states. They are 0 after reset.
- Response fields are stable while rsp_valid=1 and rsp_ready=0.

## Timing
- Reset values:
  - cmd_ready=1, fifo_count=0, busy=0
  - rsp_valid=0, rsp_result/carry/dz/tag=0
  - alu_a/b/sel=0, FSM=IDLE
- Asynchronous assertion, synchronous deassertion by design (rst_n released away from clk edge by the system). Reset mid-operation discards FIFO contents and any in-flight or held response, with no partial response.
- Latency: for a command accepted at edge N into an empty, idle block:
  - DRIVE during cycle N+1
  - CAPTURE cycle N+2
  - rsp_valid=1 from edge N+3
- Back-to-back throughput: one response per 3 cycles with rsp_ready tied high (RESP→DRIVE→CAPTURE→RESP).
- rsp_ready stalls hold RESP indefinitely. The FIFO keeps accepting until full.
- A full FIFO with a stalled response keeps cmd_ready=0 until the pop that follows rsp_ready.

## Structure
- Shared package alu_pkg holds:
  - opcode constants OP_ADD/OP_SUB/OP_MUL/OP_DIV
  - DZ_RESULT=3'b111
  - the FSM state enum
  - the command struct {a, b, op, tag}
- One sub-module: alu_cmd_fifo, a synchronous FIFO parameterised by DEPTH and width. It has push/pop/full/empty/count, and the pointers wrap mod DEPTH.
- The FSM and response register live in the top.
- The ALU is instantiated by the parent, not inside this block.

## Test plan
- Single add: a=3, b=2, op=00, tag=1 → rsp_valid 3 cycles after accept; result=5, carry=1, dz=0, tag=1.
- Wrap cases: sub 1−2 → result=7, carry=0. Mul 3*3 → result=1. Div 3/2 → result=1.
- Divide-by-zero: a=2, b=0, op=11 → result=7, dz=1. The next command (div 3/1) → result=3, dz=0.
- Backpressure/full: rsp_ready=0 and push 5 commands.
  - 1st command goes to RESP, next 4 fill the FIFO, cmd_ready=0.
  - Release rsp_ready → responses arrive in tag order, one every 3 cycles.
  - cmd_ready returns the cycle after the first pop.
- Simultaneous push/pop at count=2 → count stays 2, no command lost or duplicated.
- Reset mid-operation: assert rsp_ready low, fill 3 commands, assert rst_n=0 for 1 cycle → all outputs at reset values immediately, no rsp_valid afterwards until a new command.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, FSM states and command record for alu_initiator
//
// Contents:
//   OP_ADD/OP_SUB/OP_MUL/OP_DIV  2-bit ALU select codes
//   DZ_RESULT                    result reported for a divide by zero
//   state_t                      initiator FSM state encoding
//   cmd_t                        queued command {a, b, op, tag}
//   CMD_W                        width of cmd_t as stored in the FIFO
//   is_div_zero()                detects op=div with a zero divisor
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam logic [2:0] DZ_RESULT = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DRIVE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } state_t;

  typedef struct packed {
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] op;
    logic [1:0] tag;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

  // The ALU has no zero-divisor detection, so the initiator decides this itself.
  function automatic logic is_div_zero(input cmd_t c);
    return (c.op == OP_DIV) && (c.b == 2'b00);
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// rtl/alu_cmd_fifo.sv - synchronous first-word-fall-through command FIFO
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   i_push         write i_push_data (ignored when full)
//   i_push_data    entry to store
//   i_pop          retire the head entry (ignored when empty)
//   o_pop_data     current head entry, valid whenever !o_empty
//   o_full         count == DEPTH
//   o_empty        count == 0
//   o_count        occupancy, 0..DEPTH
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_pop_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW:0]      r_count;

  logic w_push_ok;
  logic w_pop_ok;

  assign o_full     = (r_count == FULL_COUNT);
  assign o_empty    = (r_count == '0);
  assign o_count    = r_count;
  assign o_pop_data = r_mem[r_rd_ptr];

  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/alu_initiator.sv
// rtl/alu_initiator.sv - queues ALU commands, drives the external 2-bit ALU, returns tagged results
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   cmd_valid/cmd_ready             command channel (ready = FIFO not full)
//   cmd_a, cmd_b, cmd_op, cmd_tag   command fields
//   alu_a, alu_b, alu_sel           operands/select driven to the ALU
//   alu_out, alu_carry              ALU result and carry-out
//   rsp_valid/rsp_ready             response channel
//   rsp_result, rsp_carry, rsp_dz   result, add carry, divide-by-zero flag
//   rsp_tag                         tag of the command being answered
//   busy                            FSM not idle or commands queued
//   fifo_count                      command FIFO occupancy
module alu_initiator
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_a,
  input  logic [1:0]               cmd_b,
  input  logic [1:0]               cmd_op,
  input  logic [1:0]               cmd_tag,
  output logic [1:0]               alu_a,
  output logic [1:0]               alu_b,
  output logic [1:0]               alu_sel,
  input  logic [2:0]               alu_out,
  input  logic                     alu_carry,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [2:0]               rsp_result,
  output logic                     rsp_carry,
  output logic                     rsp_dz,
  output logic [1:0]               rsp_tag,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  state_t r_state;
  state_t w_next_state;

  cmd_t r_opnd;
  cmd_t w_cmd_in;
  cmd_t w_fifo_head;

  logic [2:0] r_rsp_result;
  logic       r_rsp_carry;
  logic       r_rsp_dz;
  logic [1:0] r_rsp_tag;

  logic w_push;
  logic w_pop;
  logic w_full;
  logic w_empty;

  // ---------------------------------------------------------------------------
  // Command FIFO. Ready depends only on the registered count, so a pop in the
  // same cycle never frees a slot for a push.
  // ---------------------------------------------------------------------------
  assign w_cmd_in  = '{a: cmd_a, b: cmd_b, op: cmd_op, tag: cmd_tag};
  assign cmd_ready = !w_full;
  assign w_push    = cmd_valid && cmd_ready;

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_cmd_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_push_data (w_cmd_in),
    .i_pop       (w_pop),
    .o_pop_data  (w_fifo_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (fifo_count)
  );

  // ---------------------------------------------------------------------------
  // FSM: IDLE -> DRIVE -> CAPTURE -> RESP. DRIVE gives the ALU a full cycle to
  // settle before CAPTURE samples it. RESP chains straight into DRIVE when more
  // work is queued, giving one response every three cycles.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_next_state = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        w_next_state = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        w_next_state = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          if (!w_empty) begin
            w_pop        = 1'b1;
            w_next_state = ST_DRIVE;
          end else begin
            w_next_state = ST_IDLE;
          end
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Operand register: loaded on every pop and held otherwise, so the ALU pins
  // keep showing the last command in every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opnd <= '0;
    end else if (w_pop) begin
      r_opnd <= w_fifo_head;
    end
  end

  assign alu_a   = r_opnd.a;
  assign alu_b   = r_opnd.b;
  assign alu_sel = r_opnd.op;

  // ---------------------------------------------------------------------------
  // Response register: written only in CAPTURE, so it is stable for the whole
  // RESP stall. A zero divisor overrides whatever the ALU produced, and carry
  // is only meaningful for add.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_result <= '0;
      r_rsp_carry  <= 1'b0;
      r_rsp_dz     <= 1'b0;
      r_rsp_tag    <= '0;
    end else if (r_state == ST_CAPTURE) begin
      if (is_div_zero(r_opnd)) begin
        r_rsp_result <= DZ_RESULT;
        r_rsp_dz     <= 1'b1;
      end else begin
        r_rsp_result <= alu_out;
        r_rsp_dz     <= 1'b0;
      end
      r_rsp_carry <= (r_opnd.op == OP_ADD) ? alu_carry : 1'b0;
      r_rsp_tag   <= r_opnd.tag;
    end
  end

  assign rsp_valid  = (r_state == ST_RESP);
  assign rsp_result = r_rsp_result;
  assign rsp_carry  = r_rsp_carry;
  assign rsp_dz     = r_rsp_dz;
  assign rsp_tag    = r_rsp_tag;

  assign busy = (r_state != ST_IDLE) || !w_empty;

endmodule

// File: tb/tb_alu_initiator.sv
// tb/tb_alu_initiator.sv - self-checking bench for alu_initiator
module tb_alu_initiator;
  import alu_pkg::*;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_a, cmd_b, cmd_op, cmd_tag;
  logic [1:0] alu_a, alu_b, alu_sel;
  logic [2:0] alu_out;
  logic       alu_carry;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [2:0] rsp_result;
  logic       rsp_carry;
  logic       rsp_dz;
  logic [1:0] rsp_tag;
  logic       busy;
  logic [2:0] fifo_count;

  always #5 clk = ~clk;

  alu_initiator #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_op     (cmd_op),
    .cmd_tag    (cmd_tag),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_out    (alu_out),
    .alu_carry  (alu_carry),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_carry  (rsp_carry),
    .rsp_dz     (rsp_dz),
    .rsp_tag    (rsp_tag),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  // Behavioural 2-bit ALU. Carry is deliberately non-zero for sub/mul/div-by-0
  // and the div-by-0 result is junk, so the initiator's masking is exercised.
  function automatic logic [3:0] alu_model(input logic [1:0] a, input logic [1:0] b,
                                           input logic [1:0] sel);
    logic [2:0] s;
    logic [3:0] m;
    case (sel)
      2'b00: begin s = {1'b0, a} + {1'b0, b}; return {s[2], s}; end
      2'b01: begin s = {1'b0, a} - {1'b0, b}; return {(a < b), s}; end
      2'b10: begin m = {2'b00, a} * {2'b00, b}; return m; end
      default: begin
        if (b == 2'b00) return {1'b1, 3'b010};
        return {2'b00, a / b};
      end
    endcase
  endfunction

  assign {alu_carry, alu_out} = alu_model(alu_a, alu_b, alu_sel);

  typedef struct {
    logic [2:0] result;
    logic       carry;
    logic       dz;
    logic [1:0] tag;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks;
  int   n_fail;
  int   cyc;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t expect_of(input logic [1:0] a, input logic [1:0] b,
                                     input logic [1:0] op, input logic [1:0] tag);
    exp_t e;
    int ia;
    int ib;
    ia = int'(a);
    ib = int'(b);
    e.tag = tag;
    e.dz = 1'b0;
    e.carry = 1'b0;
    case (op)
      OP_ADD: begin e.result = 3'((ia + ib) % 8); e.carry = ((ia + ib) > 3); end
      OP_SUB: e.result = 3'((ia - ib + 8) % 8);
      OP_MUL: e.result = 3'((ia * ib) % 8);
      default: begin
        if (ib == 0) begin e.result = 3'b111; e.dz = 1'b1; end
        else e.result = 3'(ia / ib);
      end
    endcase
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Scoreboard monitor, sampling on the falling edge: accepted commands push
  // an expectation, response handshakes pop and compare.
  always @(negedge clk) begin
    if (rst_n) begin
      if (cmd_valid && cmd_ready) sb.push_back(expect_of(cmd_a, cmd_b, cmd_op, cmd_tag));
      if (rsp_valid && rsp_ready) begin
        check("rsp_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          check("rsp_result", 32'(rsp_result), 32'(mon_e.result));
          check("rsp_carry",  32'(rsp_carry),  32'(mon_e.carry));
          check("rsp_dz",     32'(rsp_dz),     32'(mon_e.dz));
          check("rsp_tag",    32'(rsp_tag),    32'(mon_e.tag));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] a, input logic [1:0] b, input logic [1:0] op,
                      input logic [1:0] tag);
    int waited = 0;
    cmd_valid = 1'b1;
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_tag = tag;
    while (!cmd_ready && waited < 50) begin tick(); waited++; end
    check("send_accept", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_quiet(input string name);
    int n = 0;
    while ((busy || rsp_valid || sb.size() != 0) && n < 60) begin tick(); n++; end
    check(name, {30'd0, busy, rsp_valid}, 32'd0);
    check({name, "_sb"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic wait_rsp_valid(input string name);
    int n = 0;
    while (!rsp_valid && n < 20) begin tick(); n++; end
    check(name, 32'(rsp_valid), 32'd1);
  endtask

  task automatic check_reset(input string name);
    check({name, "_ctl"}, {27'd0, cmd_ready, fifo_count, busy}, {27'd0, 1'b1, 3'd0, 1'b0});
    check({name, "_rsp"}, {24'd0, rsp_valid, rsp_result, rsp_carry, rsp_dz, rsp_tag}, 32'd0);
    check({name, "_alu"}, {26'd0, alu_a, alu_b, alu_sel}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int hs[$];
  logic seen_rv;

  initial begin
    n_checks = 0; n_fail = 0; cyc = 0;
    rst_n = 1'b0; cmd_valid = 1'b0;
    cmd_a = '0; cmd_b = '0; cmd_op = '0; cmd_tag = '0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    check_reset("reset");
    rst_n = 1'b1;
    tick();
    check_reset("after_release");

    // Single add with latency profile.
    send(2'd3, 2'd2, OP_ADD, 2'd1);
    check("lat_accept", {28'd0, rsp_valid, fifo_count}, {28'd0, 1'b0, 3'd1});
    tick();
    check("lat_drive", {24'd0, rsp_valid, alu_a, alu_b, alu_sel, busy},
          {24'd0, 1'b0, 2'd3, 2'd2, OP_ADD, 1'b1});
    tick();
    check("lat_capture", 32'(rsp_valid), 32'd0);
    tick();
    check("lat_resp", 32'(rsp_valid), 32'd1);
    check("lat_fields", {25'd0, rsp_result, rsp_carry, rsp_dz, rsp_tag},
          {25'd0, 3'd5, 1'b1, 1'b0, 2'd1});
    wait_quiet("single_drain");
    check("alu_hold", {26'd0, alu_a, alu_b, alu_sel}, {26'd0, 2'd3, 2'd2, OP_ADD});

    // Wrap cases and divide-by-zero followed by a normal divide.
    send(2'd1, 2'd2, OP_SUB, 2'd2);
    send(2'd3, 2'd3, OP_MUL, 2'd3);
    send(2'd3, 2'd2, OP_DIV, 2'd0);
    send(2'd2, 2'd0, OP_DIV, 2'd1);
    send(2'd3, 2'd1, OP_DIV, 2'd2);
    wait_quiet("wrap_drain");

    // Backpressure: one command parks in RESP, four fill the FIFO.
    rsp_ready = 1'b0;
    send(2'd1, 2'd1, OP_ADD, 2'd0);
    send(2'd2, 2'd1, OP_SUB, 2'd1);
    send(2'd3, 2'd2, OP_MUL, 2'd2);
    send(2'd3, 2'd3, OP_DIV, 2'd3);
    send(2'd1, 2'd0, OP_DIV, 2'd0);
    check("full_state", {27'd0, cmd_ready, fifo_count, rsp_valid}, {27'd0, 1'b0, 3'd4, 1'b1});
    repeat (4) tick();
    check("stall_hold", {24'd0, cmd_ready, fifo_count, rsp_valid, rsp_tag, rsp_result},
          {24'd0, 1'b0, 3'd4, 1'b1, 2'd0, 3'd2});
    rsp_ready = 1'b1;
    hs.delete();
    hs.push_back(cyc);
    check("ready_before_pop", 32'(cmd_ready), 32'd0);
    tick();
    check("ready_after_pop", {28'd0, cmd_ready, fifo_count}, {28'd0, 1'b1, 3'd3});
    for (int i = 0; i < 20 && hs.size() < 5; i++) begin
      if (rsp_valid) hs.push_back(cyc);
      tick();
    end
    check("bp_rsp_count", 32'(hs.size()), 32'd5);
    for (int i = 1; i < hs.size(); i++) check("bp_rsp_spacing", 32'(hs[i] - hs[i-1]), 32'd3);
    wait_quiet("bp_drain");

    // Simultaneous push and pop with two entries queued.
    rsp_ready = 1'b0;
    send(2'd1, 2'd2, OP_ADD, 2'd1);
    send(2'd2, 2'd2, OP_MUL, 2'd2);
    send(2'd3, 2'd1, OP_SUB, 2'd3);
    wait_rsp_valid("pp_resp");
    check("pp_pre", {28'd0, cmd_ready, fifo_count}, {28'd0, 1'b1, 3'd2});
    cmd_valid = 1'b1;
    cmd_a = 2'd2; cmd_b = 2'd1; cmd_op = OP_DIV; cmd_tag = 2'd0;
    rsp_ready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    check("pp_count", 32'(fifo_count), 32'd2);
    wait_quiet("pp_drain");

    // Reset while a response is held and commands are queued.
    rsp_ready = 1'b0;
    send(2'd1, 2'd1, OP_ADD, 2'd1);
    send(2'd2, 2'd1, OP_SUB, 2'd2);
    send(2'd3, 2'd3, OP_MUL, 2'd3);
    wait_rsp_valid("rst_pre_resp");
    rst_n = 1'b0;
    #2;
    check_reset("mid_reset");
    tick();
    rst_n = 1'b1;
    sb.delete();
    rsp_ready = 1'b1;
    seen_rv = 1'b0;
    repeat (8) begin
      tick();
      if (rsp_valid) seen_rv = 1'b1;
    end
    check("post_reset_no_rsp", 32'(seen_rv), 32'd0);
    check("post_reset_idle", {27'd0, busy, fifo_count, cmd_ready}, {27'd0, 1'b0, 3'd0, 1'b1});
    send(2'd3, 2'd3, OP_ADD, 2'd3);
    wait_quiet("post_reset_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
